store_buffer: RTL

- Write-side counterpart to the MEM/WB load path.
- Sits between the MEM stage and the data-memory/bridge bus.
- Aligns sb/sh/sw store data into byte lanes, generates byte enables, detects misaligned stores (AdES), and queues accepted stores in a small FIFO.
- Drains the FIFO over a req/ack bus and stalls the pipeline on buffer-full or on a load hitting a pending store word.

---
 rtl/store_buffer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer: aligns sb/sh/sw into byte lanes, flags AdES, queues stores and drains them in order over req/ack.
// Pushed entry reaches the bus the cycle after the edge; MEM stalls when full without a pop, or when a load hits a pending word.
module store_buffer #(
  parameter int DEPTH = 2,
  parameter int PTRW  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      MEMStoreType,
  input  logic [31:0]     MEMAddr,
  input  logic [31:0]     MEMStoreData,
  input  logic [31:0]     MEMPC,
  input  logic            MEMFlush,
  input  logic            MEMLoadValid,
  input  logic [31:0]     MEMLoadAddr,
  output logic            MEMStall,
  output logic            MEMAdES,
  output logic [PTRW:0]   StoreCount,
  output logic            BusReq,
  output logic [31:0]     BusAddr,
  output logic [31:0]     BusWData,
  output logic [3:0]      BusByteEn,
  output logic [31:0]     BusPC,
  input  logic            BusAck
);

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
  } entry_t;

  localparam logic [PTRW:0]   FULL_CNT = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   CNT_ONE  = (PTRW+1)'(1);
  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);

  entry_t            mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTRW-1:0]   rd_ptr;
  logic [PTRW-1:0]   wr_ptr;
  logic [PTRW:0]     count;

  entry_t            new_entry;
  entry_t            head;
  logic              store_valid;
  logic              store_stall;
  logic              load_hit;
  logic              pop;
  logic              push;
  logic              unused_load_lsbs;

  assign unused_load_lsbs = &{1'b0, MEMLoadAddr[1:0]};

  assign MEMAdES = ((MEMStoreType == 2'd2) && MEMAddr[0]) ||
                   ((MEMStoreType == 2'd3) && (MEMAddr[1:0] != 2'b00));

  // Lane replication lets the bus pick bytes purely by byte enable.
  always_comb begin
    new_entry       = '0;
    new_entry.waddr = MEMAddr[31:2];
    new_entry.pc    = MEMPC;
    case (MEMStoreType)
      2'd1: begin
        new_entry.be    = 4'b0001 << MEMAddr[1:0];
        new_entry.wdata = {4{MEMStoreData[7:0]}};
      end
      2'd2: begin
        new_entry.be    = MEMAddr[1] ? 4'b1100 : 4'b0011;
        new_entry.wdata = {2{MEMStoreData[15:0]}};
      end
      2'd3: begin
        new_entry.be    = 4'b1111;
        new_entry.wdata = MEMStoreData;
      end
      default: begin
        new_entry.be    = 4'b0000;
        new_entry.wdata = '0;
      end
    endcase
  end

  // Word-granular match: partial overlaps still stall rather than forward.
  always_comb begin
    load_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (MEMLoadValid && valid[i] && (mem[i].waddr == MEMLoadAddr[31:2]))
        load_hit = 1'b1;
    end
  end

  assign head        = mem[rd_ptr];
  assign BusReq      = (count != '0);
  assign pop         = BusReq && BusAck;
  assign store_valid = (MEMStoreType != 2'd0) && !MEMAdES && !MEMFlush;
  assign store_stall = store_valid && (count == FULL_CNT) && !pop;
  assign MEMStall    = store_stall || load_hit;
  assign push        = store_valid && !MEMStall;

  assign BusAddr    = BusReq ? {head.waddr, 2'b00} : 32'h0;
  assign BusWData   = BusReq ? head.wdata : 32'h0;
  assign BusByteEn  = BusReq ? head.be : 4'h0;
  assign BusPC      = BusReq ? head.pc : 32'h0;
  assign StoreCount = count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      valid  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_ONE;
      end
      // When full, push and pop share a slot; the push must win the valid bit.
      if (push) begin
        mem[wr_ptr]   <= new_entry;
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
